actquant_seq: RTL and testbench
===============================

# actquant_seq

Sequencer for the activation requantizer stage. After a layer's accumulation completes, it streams the channel-major partial sums from the psum SRAM through the external 2-cycle requantizer (multiply by per-channel scale, arithmetic >>16, clip to int8). It packs four int8 results per 32-bit word and writes them to the activation SRAM. It sits between the accumulator buffer and the next layer's input buffer, and is started once per layer by the top-level layer controller.

## Interface
- PARAM_BIT, 8, quantized activation width
- PARTIAL_BIT, 25, partial-sum width
- CH_W, 8, channel-count width
- PIX_W, 12, pixels-per-channel width
- ADDR_W, 16, SRAM address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- ch_num  in  CH_W  channel count; sampled with start
- pix_num  in  PIX_W  pixels per channel; sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- scale_addr  out  CH_W  scale RF read address; data returned next cycle
- scale_rdata  in  16  signed scale
- psum_cen  out  1  psum read enable, active-high; data next cycle
- psum_addr  out  ADDR_W  psum read address
- psum_rdata  in  PARTIAL_BIT  signed partial sum
- q_scale  out  16  scale to requantizer (registered)
- q_act_in  out  PARTIAL_BIT  equals psum_rdata (combinational pass-through)
- q_act_out  in  PARAM_BIT  requantizer result, 2 cycles after q_act_in
- act_wen  out  1  activation write enable, active-high
- act_bwe  out  4  byte enables; bit i covers bits 8i+7:8i
- act_addr  out  ADDR_W  activation word address
- act_wdata  out  32  packed activations

## Operation
- FSM states: IDLE, LD_SCALE, STREAM, DRAIN, DONE.
- IDLE + start: if ch_num==0 or pix_num==0, go to DONE with no memory access. Otherwise, latch both counts, clear ch/pix/psum_addr/act_addr, and go to LD_SCALE.
- LD_SCALE (1 cycle): scale_addr=ch. Next: STREAM. On entry to STREAM, scale_rdata is latched into q_scale.
- STREAM (pix_num cycles): psum_cen=1, psum_addr increments each cycle. On the last pixel, go to DRAIN.
- DRAIN (3 cycles): lets the last result exit. Next: LD_SCALE if ch+1<ch_num, else DONE.
- DONE (1 cycle): done=1. Next: IDLE.
- A 3-stage valid shift register tracks in-flight reads (1 SRAM cycle + 2 quantizer cycles). The lane counter is pixel index mod 4; lane 0 maps to the low byte.
- A word is written when lane==3 or when it holds the last pixel of the channel. act_bwe marks the filled lanes only, so a tail word gets a partial mask.
- Each channel starts a new word. act_addr increments after every write; psum_addr runs linearly across channels.
- q_scale is held constant for the whole channel; it changes only when the pipeline is empty.
- start while busy is ignored. ch_num/pix_num changes after acceptance have no effect.

## Timing
- Reset (async assert, any state): FSM goes to IDLE. busy, done, psum_cen, act_wen, act_bwe, all addresses, q_scale and act_wdata are 0. The packer and valid pipe are cleared, and no write completes.
- Read issued in cycle t → q_act_in valid in t+1 → q_act_out valid in t+3 → write (if packed) issued in t+3.
- Per-channel cost: pix_num+4 cycles. done asserts ch_num*(pix_num+4)+1 cycles after the accepted start cycle; busy drops in that same cycle.
- Degenerate start (zero count): done in the cycle after start, and busy stays 0.

## Structure
- Package actquant_seq_pkg holds:
  - state enum
  - PIPE_LAT=3
  - LANES=4
- Sub-module act_packer: byte-lane accumulator with valid-in, last-in, and word/bwe/wen-out.
- The FSM, counters and valid pipe live in the top.

## Test plan
- ch_num=1, pix_num=4, scale=16384, psums 400,-300,1000000,-1000000 → one write at addr 0, bwe=4'hF, wdata=32'h80_7F_B5_64 (100,-75,127,-128).
- ch_num=2, pix_num=6, scale[0]=256, scale[1]=-256, all psums 25600:
  - Writes at addr 0..3.
  - Words 0 and 2: bwe=4'hF. Words 1 and 3: bwe=4'h3.
  - Ch0 bytes = 0x64, ch1 bytes = 0x9C.
  - done at cycle 21.
- ch_num=0 → done the cycle after start, and psum_cen/act_wen never assert.
- start pulsed again mid-STREAM → ignored; write count and addresses are identical to the single-start run.
- rst_n asserted mid-STREAM of channel 1 → all outputs are 0 immediately and no further writes occur. A fresh start after release completes normally from addr 0.
- Back-to-back layers: start asserted in the cycle after done → accepted; the second run's writes restart at act_addr 0.

Source files
------------

// File: rtl/actquant_seq_pkg.sv
// Shared types and constants for the activation requantizer sequencer.
package actquant_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_SCALE = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // In-flight depth: one psum SRAM read cycle plus two requantizer cycles.
  localparam int PIPE_LAT = 3;
  // Number of int8 lanes packed into one 32-bit activation word.
  localparam int LANES    = 4;

endpackage

// File: rtl/actquant_seq_packer.sv
// act_packer: collects requantized bytes into a word, lane 0 in the low byte.
// A word is emitted in the same cycle its final byte arrives, either when the
// top lane fills or when the byte is the last pixel of its channel.
import actquant_seq_pkg::*;

module act_packer #(
  parameter int PARAM_BIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic [PARAM_BIT-1:0]       i_data,
  output logic                       o_wen,
  output logic [LANES-1:0]           o_bwe,
  output logic [LANES*PARAM_BIT-1:0] o_wdata
);

  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0]          r_lane;
  logic [LANES-1:0]           r_bwe;
  logic [LANES*PARAM_BIT-1:0] r_word;

  logic [LANES-1:0]           w_mask;
  logic [LANES*PARAM_BIT-1:0] w_merged;
  logic                       w_flush;

  // Merge the incoming byte into the partial word and decide whether to write.
  always_comb begin
    w_mask   = LANES'(1) << r_lane;
    w_merged = r_word;
    w_merged[r_lane*PARAM_BIT +: PARAM_BIT] = i_data;
    w_flush  = i_valid && ((r_lane == LANE_W'(LANES-1)) || i_last);
    o_wen    = w_flush;
    o_bwe    = w_flush ? (r_bwe | w_mask) : '0;
    o_wdata  = w_flush ? w_merged : '0;
  end

  // Accumulate lanes; restart at lane 0 after every emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_bwe  <= '0;
      r_word <= '0;
    end else if (i_valid) begin
      if (w_flush) begin
        r_lane <= '0;
        r_bwe  <= '0;
        r_word <= '0;
      end else begin
        r_lane <= r_lane + LANE_W'(1);
        r_bwe  <= r_bwe | w_mask;
        r_word <= w_merged;
      end
    end
  end

endmodule

// File: rtl/actquant_seq.sv
// actquant_seq: streams channel-major partial sums through the external
// 2-cycle requantizer and packs the int8 results into activation SRAM words.
//
// Handshake: start is a single-cycle request honoured only in IDLE; the
// counts are captured with it. busy is high from the next cycle until the
// DONE cycle, in which done pulses once. Memory reads return one cycle after
// the address/enable; writes are single-cycle act_wen strobes with act_bwe.
import actquant_seq_pkg::*;

module actquant_seq #(
  parameter int PARAM_BIT   = 8,
  parameter int PARTIAL_BIT = 25,
  parameter int CH_W        = 8,
  parameter int PIX_W       = 12,
  parameter int ADDR_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CH_W-1:0]        ch_num,
  input  logic [PIX_W-1:0]       pix_num,
  output logic                   busy,
  output logic                   done,
  output logic [CH_W-1:0]        scale_addr,
  input  logic [15:0]            scale_rdata,
  output logic                   psum_cen,
  output logic [ADDR_W-1:0]      psum_addr,
  input  logic [PARTIAL_BIT-1:0] psum_rdata,
  output logic [15:0]            q_scale,
  output logic [PARTIAL_BIT-1:0] q_act_in,
  input  logic [PARAM_BIT-1:0]   q_act_out,
  output logic                   act_wen,
  output logic [3:0]             act_bwe,
  output logic [ADDR_W-1:0]      act_addr,
  output logic [31:0]            act_wdata,
  output state_t                 dbg_state
);

  state_t              r_state;
  state_t              w_next;
  logic [CH_W-1:0]     r_ch_num;
  logic [PIX_W-1:0]    r_pix_num;
  logic [CH_W-1:0]     r_ch;
  logic [PIX_W-1:0]    r_pix;
  logic [ADDR_W-1:0]   r_psum_addr;
  logic [ADDR_W-1:0]   r_act_addr;
  logic [15:0]         r_q_scale;
  logic [1:0]          r_drain_cnt;
  logic [PIPE_LAT-1:0] r_vld;
  logic [PIPE_LAT-1:0] r_last;

  logic                w_accept;
  logic                w_zero;
  logic                w_last_pix;
  logic                w_drain_end;
  logic                w_more_ch;
  logic [CH_W:0]       w_ch_inc;
  logic                w_wen;
  logic [3:0]          w_bwe;
  logic [31:0]         w_wdata;

  // Decode control conditions used by both the next-state logic and counters.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && start;
    w_zero      = (ch_num == '0) || (pix_num == '0);
    w_last_pix  = (r_pix == (r_pix_num - PIX_W'(1)));
    w_drain_end = (r_drain_cnt == 2'(PIPE_LAT-1));
    w_ch_inc    = {1'b0, r_ch} + (CH_W+1)'(1);
    w_more_ch   = (w_ch_inc < {1'b0, r_ch_num});
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = w_zero ? S_DONE : S_LD_SCALE;
      S_LD_SCALE: w_next = S_STREAM;
      S_STREAM:   if (w_last_pix) w_next = S_DRAIN;
      S_DRAIN:    if (w_drain_end) w_next = w_more_ch ? S_LD_SCALE : S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Layer counters, read address, per-channel scale latch and drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_num    <= '0;
      r_pix_num   <= '0;
      r_ch        <= '0;
      r_pix       <= '0;
      r_psum_addr <= '0;
      r_q_scale   <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_zero) begin
            r_ch_num    <= ch_num;
            r_pix_num   <= pix_num;
            r_ch        <= '0;
            r_pix       <= '0;
            r_psum_addr <= '0;
            r_drain_cnt <= '0;
          end
        end
        S_STREAM: begin
          // The scale read issued in LD_SCALE is valid now; the pipeline is
          // empty, so switching the scale cannot corrupt an in-flight pixel.
          if (r_pix == '0) r_q_scale <= scale_rdata;
          r_psum_addr <= r_psum_addr + ADDR_W'(1);
          r_pix       <= w_last_pix ? '0 : r_pix + PIX_W'(1);
        end
        S_DRAIN: begin
          if (w_drain_end) begin
            r_drain_cnt <= '0;
            if (w_more_ch) r_ch <= w_ch_inc[CH_W-1:0];
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid/last shift register following each read to the requantizer output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_last <= '0;
    end else begin
      r_vld  <= {r_vld[PIPE_LAT-2:0],  (r_state == S_STREAM)};
      r_last <= {r_last[PIPE_LAT-2:0], (r_state == S_STREAM) && w_last_pix};
    end
  end

  // Activation write address advances once per emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_act_addr <= '0;
    else if (w_accept && !w_zero)      r_act_addr <= '0;
    else if (w_wen)                    r_act_addr <= r_act_addr + ADDR_W'(1);
  end

  act_packer #(.PARAM_BIT(PARAM_BIT)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_vld[PIPE_LAT-1]),
    .i_last  (r_last[PIPE_LAT-1]),
    .i_data  (q_act_out),
    .o_wen   (w_wen),
    .o_bwe   (w_bwe),
    .o_wdata (w_wdata)
  );

  // Output drive.
  always_comb begin
    busy       = (r_state == S_LD_SCALE) || (r_state == S_STREAM) ||
                 (r_state == S_DRAIN);
    done       = (r_state == S_DONE);
    scale_addr = r_ch;
    psum_cen   = (r_state == S_STREAM);
    psum_addr  = r_psum_addr;
    q_scale    = r_q_scale;
    q_act_in   = psum_rdata;
    act_wen    = w_wen;
    act_bwe    = w_bwe;
    act_addr   = r_act_addr;
    act_wdata  = w_wdata;
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_actquant_seq.sv
// Bench for actquant_seq: behavioural SRAMs and requantizer, a write
// scoreboard, a table of layer shapes and hand-written corner sequences.
import actquant_seq_pkg::*;

module tb_actquant_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  ch_num;
  logic [11:0] pix_num;
  logic        busy, done;
  logic [7:0]  scale_addr;
  logic [15:0] scale_rdata;
  logic        psum_cen;
  logic [15:0] psum_addr;
  logic [24:0] psum_rdata;
  logic [15:0] q_scale;
  logic [24:0] q_act_in;
  logic [7:0]  q_act_out;
  logic        act_wen;
  logic [3:0]  act_bwe;
  logic [15:0] act_addr;
  logic [31:0] act_wdata;
  state_t      dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  actquant_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_num(ch_num), .pix_num(pix_num),
    .busy(busy), .done(done), .scale_addr(scale_addr), .scale_rdata(scale_rdata),
    .psum_cen(psum_cen), .psum_addr(psum_addr), .psum_rdata(psum_rdata),
    .q_scale(q_scale), .q_act_in(q_act_in), .q_act_out(q_act_out),
    .act_wen(act_wen), .act_bwe(act_bwe), .act_addr(act_addr),
    .act_wdata(act_wdata), .dbg_state(dbg_state)
  );

  // ---------------- memories and requantizer model ----------------
  logic signed [15:0] scale_rf [256];
  logic signed [24:0] psum_mem [4096];
  logic [7:0] r_q1, r_q2;

  function automatic logic [7:0] quant(input logic signed [24:0] a,
                                       input logic signed [15:0] s);
    longint p;
    p = longint'(a) * longint'(s);
    p = p >>> 16;
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    return p[7:0];
  endfunction

  always @(posedge clk) begin
    scale_rdata <= scale_rf[scale_addr];
    if (psum_cen) psum_rdata <= psum_mem[psum_addr[11:0]];
    r_q1 <= quant(q_act_in, q_scale);
    r_q2 <= r_q1;
  end
  assign q_act_out = r_q2;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cen_cnt = 0;
  int wen_cnt = 0;
  logic [51:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    exp_q.push_back({a, b, d});
  endtask

  // Independent reference: pack quantized pixels channel by channel.
  task automatic push_model(input int nch, input int npix);
    logic [15:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    int lane;
    a = 0;
    for (int c = 0; c < nch; c++) begin
      lane = 0; b = 0; d = 0;
      for (int p = 0; p < npix; p++) begin
        d[lane*8 +: 8] = quant(psum_mem[c*npix + p], scale_rf[c]);
        b[lane] = 1'b1;
        if (lane == 3 || p == npix - 1) begin
          push_exp(a, b, d);
          a++; lane = 0; b = 0; d = 0;
        end else begin
          lane++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic [51:0] e;
    logic [31:0] m;
    if (psum_cen) cen_cnt++;
    if (act_wen) begin
      wen_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {act_addr, act_bwe, act_wdata}, 0);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{e[32+i]}};
        check("write", {act_addr, act_bwe, act_wdata & m}, {e[51:32], e[31:0] & m});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_layer(input int nch, input int npix, input int mid_at,
                           output int done_n, output logic busy1, output logic busy_d);
    int n;
    @(negedge clk);
    start = 1'b1; ch_num = 8'(nch); pix_num = 12'(npix);
    n = 0; done_n = -1; busy1 = 1'b0; busy_d = 1'b1;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; busy1 = busy;
        ch_num = 8'($urandom_range(0, 255)); pix_num = 12'($urandom_range(0, 4095));
      end
      if (mid_at != 0 && n == mid_at)     start = 1'b1;
      if (mid_at != 0 && n == mid_at + 1) start = 1'b0;
      if (done) begin
        done_n = n; busy_d = busy;
        break;
      end
    end
    if (done_n < 0) check("done_timeout", n, 0);
  endtask

  task automatic check_zero(input string name);
    check(name, {busy, done, psum_cen, act_wen, act_bwe, scale_addr, psum_addr,
                 act_addr, q_scale, act_wdata, dbg_state}, 0);
  endtask

  task automatic load_t1();
    scale_rf[0] = 16'sd16384;
    psum_mem[0] = 25'sd400;     psum_mem[1] = -25'sd300;
    psum_mem[2] = 25'sd1000000; psum_mem[3] = -25'sd1000000;
  endtask

  task automatic load_t2();
    scale_rf[0] = 16'sd256; scale_rf[1] = -16'sd256;
    for (int i = 0; i < 12; i++) psum_mem[i] = 25'sd25600;
  endtask

  task automatic push_t2();
    push_exp(16'd0, 4'hF, 32'h64646464); push_exp(16'd1, 4'h3, 32'h00006464);
    push_exp(16'd2, 4'hF, 32'h9C9C9C9C); push_exp(16'd3, 4'h3, 32'h00009C9C);
  endtask

  typedef struct { int nch; int npix; int exp_done; } vec_t;
  vec_t vecs[8];

  initial begin
    int dn, c0, w0, n;
    logic b1, bd;
    rst_n = 1'b0; start = 1'b0; ch_num = 0; pix_num = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Spec example 1: single full word with clipping.
    load_t1();
    push_exp(16'd0, 4'hF, 32'h807FB564);
    run_layer(1, 4, 0, dn, b1, bd);
    check("t1_done_cycle", dn, 9);
    check("t1_busy", {b1, bd}, 2'b10);
    check("t1_drain", exp_q.size(), 0);

    // Spec example 2: two channels with tail words.
    load_t2(); push_t2();
    run_layer(2, 6, 0, dn, b1, bd);
    check("t2_done_cycle", dn, 21);
    check("t2_drain", exp_q.size(), 0);

    // Zero channel count: immediate done, no memory traffic.
    c0 = cen_cnt; w0 = wen_cnt;
    run_layer(0, 5, 0, dn, b1, bd);
    check("zero_done_cycle", dn, 1);
    check("zero_busy", {b1, bd}, 2'b00);
    check("zero_no_access", cen_cnt - c0 + wen_cnt - w0, 0);

    // Start pulsed mid-STREAM is ignored.
    push_t2(); w0 = wen_cnt;
    run_layer(2, 6, 14, dn, b1, bd);
    check("midstart_done_cycle", dn, 21);
    check("midstart_writes", wen_cnt - w0, 4);
    check("midstart_drain", exp_q.size(), 0);

    // Reset during channel 1 STREAM.
    push_t2();
    @(negedge clk);
    start = 1'b1; ch_num = 8'd2; pix_num = 12'd6;
    n = 0;
    while (n < 13) begin
      @(negedge clk); n++;
      if (n == 1) start = 1'b0;
    end
    check("rst_state_before", dbg_state, S_STREAM);
    rst_n = 1'b0;
    #1;
    check_zero("rst_outputs");
    check("rst_pending_words", exp_q.size(), 2);
    exp_q.delete();
    w0 = wen_cnt;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_writes", wen_cnt - w0, 0);
    check("rst_idle", dbg_state, S_IDLE);

    // Fresh start after reset, then a back-to-back layer.
    load_t1();
    push_exp(16'd0, 4'hF, 32'h807FB564);
    run_layer(1, 4, 0, dn, b1, bd);
    check("post_rst_done", dn, 9);
    push_exp(16'd0, 4'hF, 32'h807FB564);
    run_layer(1, 4, 0, dn, b1, bd);
    check("b2b_done", dn, 9);
    check("b2b_drain", exp_q.size(), 0);

    // Table of shapes with random scales and partial sums.
    vecs[0] = '{1, 4, 9};  vecs[1] = '{2, 6, 21}; vecs[2] = '{3, 1, 16};
    vecs[3] = '{1, 9, 14}; vecs[4] = '{2, 8, 25}; vecs[5] = '{0, 5, 1};
    vecs[6] = '{4, 0, 1};  vecs[7] = '{1, 3, 8};
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 8; c++) scale_rf[c] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 80; i++)
        psum_mem[i] = ($urandom_range(0, 1) == 1) ? 25'($urandom_range(0, 33554431))
                                                  : 25'(int'($urandom_range(0, 4000)) - 2000);
      push_model(vecs[v].nch, vecs[v].npix);
      run_layer(vecs[v].nch, vecs[v].npix, 0, dn, b1, bd);
      check($sformatf("vec%0d_done", v), dn, vecs[v].exp_done);
      check($sformatf("vec%0d_busy", v), {b1, bd}, {(vecs[v].exp_done != 1), 1'b0});
      check($sformatf("vec%0d_drain", v), exp_q.size(), 0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
